lf_prefix_sum128: RTL and testbench

LF_PREFIX_SUM128 -- requirements
Module: lf_prefix_sum128

---
 rtl/lf_prefix_sum128_pkg.sv | 20 ++
 rtl/lf_prefix_sum128_if.sv | 20 ++
 rtl/lf_prefix_sum128_level.sv | 30 +++
 rtl/lf_prefix_sum128.sv | 81 ++++++++
 tb/tb_lf_prefix_sum128.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lf_prefix_sum128_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfps_pkg : shared constants, lane-sum type and prefix-source helper  |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package lfps_pkg;

  localparam int N      = 128;
  localparam int W      = 8;
  localparam int LEVELS = 7;

  typedef logic [W-1:0] lane_sum_t;

  // Lane whose running sum is folded into lane i at level k.
  function automatic int src_lane(input int i, input int k);
    return ((i >> (k + 1)) << (k + 1)) + (1 << k) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lf_prefix_sum128_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lf_prefix_sum128_if : mask in / prefix sums out bundle               |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
interface lf_prefix_sum128_if #(
  parameter int N = lfps_pkg::N,
  parameter int W = lfps_pkg::W
);

  logic           in_valid;
  logic [N-1:0]   mask;
  logic           out_valid;
  logic [N*W-1:0] psum;

  modport master (output in_valid, output mask, input out_valid, input psum);
  modport slave  (input in_valid, input mask, output out_valid, output psum);

endinterface
`default_nettype wire

// File: rtl/lf_prefix_sum128_level.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfps_level : one combinational Ladner-Fischer level (index K)        |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module lfps_level #(
  parameter int K = 0,
  parameter int N = lfps_pkg::N,
  parameter int W = lfps_pkg::W
) (
  input  logic [N*W-1:0] d_i,
  output logic [N*W-1:0] d_o
);
  import lfps_pkg::*;

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (((i >> K) & 1) == 1) begin : g_add
      localparam int SRC = src_lane(i, K);
      lane_sum_t w_own;
      lane_sum_t w_src;
      assign w_own             = d_i[i*W +: W];
      assign w_src             = d_i[SRC*W +: W];
      assign d_o[i*W +: W]     = w_own + w_src;
    end else begin : g_pass
      assign d_o[i*W +: W]     = d_i[i*W +: W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/lf_prefix_sum128.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lf_prefix_sum128 : 128-lane inclusive popcount prefix, LF network    |
// | LFPS_PIPE_EN adds a register after level 3 (latency 2). Rev 1.0      |
// +----------------------------------------------------------------------+
module lf_prefix_sum128 #(
  parameter int N = lfps_pkg::N,
  parameter int W = lfps_pkg::W
) (
  input  logic               clk,
  input  logic               reset,
  lf_prefix_sum128_if.slave  bus
);
  import lfps_pkg::*;

  localparam int PIPE_AFTER = 4;

  logic [N*W-1:0] w_lvl0;
  logic [N*W-1:0] w_lvl [0:LEVELS];
  logic [N*W-1:0] w_mid;
  logic           w_mid_valid;
  logic [N*W-1:0] psum_d;
  logic [N*W-1:0] psum_q;
  logic           out_valid_q;

  always_comb begin
    w_lvl0 = '0;
    for (int i = 0; i < N; i++) begin
      w_lvl0[i*W] = bus.mask[i];
    end
  end

  assign w_lvl[0] = w_lvl0;

`ifdef LFPS_PIPE_EN
  logic [N*W-1:0] mid_q;
  logic           mid_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mid_q       <= '0;
      mid_valid_q <= 1'b0;
    end else begin
      mid_q       <= w_lvl[PIPE_AFTER];
      mid_valid_q <= bus.in_valid;
    end
  end

  assign w_mid       = mid_q;
  assign w_mid_valid = mid_valid_q;
`else
  assign w_mid       = w_lvl[PIPE_AFTER];
  assign w_mid_valid = bus.in_valid;
`endif

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    if (k == PIPE_AFTER) begin : g_from_mid
      lfps_level #(.K(k), .N(N), .W(W)) u_level (.d_i(w_mid),    .d_o(w_lvl[k+1]));
    end else begin : g_from_prev
      lfps_level #(.K(k), .N(N), .W(W)) u_level (.d_i(w_lvl[k]), .d_o(w_lvl[k+1]));
    end
  end

  // Invalid cycles leave the last result on psum.
  assign psum_d = w_mid_valid ? w_lvl[LEVELS] : psum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      psum_q      <= psum_d;
      out_valid_q <= w_mid_valid;
    end
  end

  assign bus.psum      = psum_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lf_prefix_sum128.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lf_prefix_sum128 : vector table, streams and reset for the DUT    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module tb_lf_prefix_sum128;
  import lfps_pkg::*;

`ifdef LFPS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] P26 = 32'b00001000000010000010000000010011;
  localparam logic [31:0] P27 = 32'b00100001000100100100010100000000;
  localparam logic [31:0] P28 = 32'b01001011101000100100011101011101;
  localparam logic [N-1:0] ONES  = {N{1'b1}};
  localparam logic [N-1:0] ZEROS = {N{1'b0}};
  localparam int NV = 21;

  typedef struct {
    logic [N-1:0] mask;
    int           lane;
    int           value;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  lf_prefix_sum128_if bus ();

  lf_prefix_sum128 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  logic [N*W-1:0] exp_psum;
  logic           stim_v [0:255];
  logic [N-1:0]   stim_m [0:255];
  vec_t           vecs   [0:NV-1];

  // Inclusive running popcount, lane by lane.
  function automatic logic [N*W-1:0] ref_psum(input logic [N-1:0] m);
    logic [N*W-1:0] r;
    int             cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt += int'(m[i]);
      r[i*W +: W] = lane_sum_t'(cnt);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rep4(input logic [31:0] p);
    return {p, p, p, p};
  endfunction

  function automatic logic [N-1:0] rand_mask();
    logic [N-1:0] a, b, c;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 4))
      0:       return a;
      1:       return ONES;
      2:       return ZEROS;
      3:       return a & b & c;
      default: return ONES >> $urandom_range(0, N - 1);
    endcase
  endfunction

  task automatic chk_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_psum(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
      end
      $display("FAIL %s: lane %0d got %0h, want %0h", name, bad, act[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  // Drive stim[0..nc-1] on consecutive cycles; each output is checked LAT cycles later.
  task automatic run_stream(input int nc);
    for (int c = 0; c < nc + LAT; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        chk_val("stream out_valid", int'(bus.out_valid), int'(stim_v[c-LAT]));
        if (stim_v[c-LAT]) exp_psum = ref_psum(stim_m[c-LAT]);
        chk_psum("stream psum", bus.psum, exp_psum);
      end
      if (c < nc) begin
        bus.in_valid = stim_v[c];
        bus.mask     = stim_m[c];
      end else begin
        bus.in_valid = 1'b0;
        bus.mask     = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  initial begin
    vecs[0]  = '{rep4(P26), 0, 1};
    vecs[1]  = '{rep4(P26), 1, 2};
    vecs[2]  = '{rep4(P26), 4, 3};
    vecs[3]  = '{rep4(P26), 31, 6};
    vecs[4]  = '{rep4(P26), 127, 24};
    vecs[5]  = '{rep4(P27), 0, 0};
    vecs[6]  = '{rep4(P27), 7, 0};
    vecs[7]  = '{rep4(P27), 8, 1};
    vecs[8]  = '{rep4(P27), 10, 2};
    vecs[9]  = '{rep4(P27), 31, 7};
    vecs[10] = '{rep4(P27), 127, 28};
    vecs[11] = '{rep4(P28), 0, 1};
    vecs[12] = '{rep4(P28), 1, 1};
    vecs[13] = '{rep4(P28), 2, 2};
    vecs[14] = '{rep4(P28), 3, 3};
    vecs[15] = '{rep4(P28), 31, 16};
    vecs[16] = '{rep4(P28), 127, 64};
    vecs[17] = '{ONES, 0, 1};
    vecs[18] = '{ONES, 63, 64};
    vecs[19] = '{ONES, 127, 8'h80};
    vecs[20] = '{ZEROS, 127, 0};

    bus.in_valid = 1'b0;
    bus.mask     = '0;
    exp_psum     = '0;

    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_val("reset out_valid", int'(bus.out_valid), 0);
    chk_psum("reset psum", bus.psum, '0);
    reset = 1'b0;

    for (int t = 0; t < NV; t++) begin
      stim_v[0] = 1'b1;
      stim_m[0] = vecs[t].mask;
      run_stream(1);
      chk_val($sformatf("vec%0d lane%0d", t, vecs[t].lane),
              int'(bus.psum[vecs[t].lane*W +: W]), vecs[t].value);
    end

    stim_v[0] = 1'b1;
    stim_m[0] = ONES;
    run_stream(1);
    for (int i = 0; i < N; i++) begin
      chk_val($sformatf("ones lane%0d", i), int'(bus.psum[i*W +: W]), i + 1);
    end

    // Back-to-back spec masks with a bubble, then random traffic.
    stim_v[0] = 1'b1; stim_m[0] = rep4(P26);
    stim_v[1] = 1'b1; stim_m[1] = rep4(P27);
    stim_v[2] = 1'b1; stim_m[2] = rep4(P28);
    stim_v[3] = 1'b1; stim_m[3] = ONES;
    stim_v[4] = 1'b0; stim_m[4] = rep4(P27);
    stim_v[5] = 1'b1; stim_m[5] = ZEROS;
    stim_v[6] = 1'b1; stim_m[6] = rep4(P26);
    run_stream(7);

    for (int c = 0; c < 200; c++) begin
      stim_v[c] = ($urandom_range(0, 3) != 0);
      stim_m[c] = rand_mask();
    end
    run_stream(200);

    // Reset with results in flight.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mask     = rep4(P28);
    @(negedge clk);
    bus.mask     = ONES;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_val("async reset out_valid", int'(bus.out_valid), 0);
    chk_psum("async reset psum", bus.psum, '0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_val("held reset out_valid", int'(bus.out_valid), 0);
    reset    = 1'b0;
    exp_psum = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_val("post-reset out_valid", int'(bus.out_valid), 0);
      chk_psum("post-reset psum", bus.psum, '0);
    end

    stim_v[0] = 1'b1;
    stim_m[0] = rep4(P27);
    run_stream(1);
    chk_val("first after reset lane127", int'(bus.psum[127*W +: W]), 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
